// File: rtl/reg_bank_wb_pkg.sv
// Shared processor constants for the register bank: data width, address width
// and the number of architectural registers.
package reg_bank_wb_pkg;

    localparam int PROC_DATA_W    = 32;
    localparam int PROC_ADDR_W    = 5;
    localparam int PROC_REG_COUNT = 32;

endpackage

// File: rtl/reg_bank_wb_scoreboard.sv
// Busy-bit scoreboard: one bit per register marking an issued producer whose
// result has not yet committed into the array.
module reg_scoreboard
    import reg_bank_wb_pkg::*;
#(
    parameter int ADDR_W    = PROC_ADDR_W,
    parameter int REG_COUNT = PROC_REG_COUNT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 set_en,
    input  logic [ADDR_W-1:0]    set_dir,
    input  logic                 clr_en,
    input  logic [ADDR_W-1:0]    clr_dir,
    output logic [REG_COUNT-1:0] busy
);

    // The set is applied after the clear so a newer producer issued on the
    // commit edge of an older one keeps the register reserved.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= '0;
        end else begin
            if (clr_en) begin
                busy[clr_dir] <= 1'b0;
            end
            if (set_en && (set_dir != '0)) begin
                busy[set_dir] <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_bank_wb.sv
// Register bank with a one-deep write-back stage, read bypass from that stage
// and a busy-bit scoreboard that raises stall on pending source operands.
module reg_bank_wb
    import reg_bank_wb_pkg::*;
#(
    parameter int DATA_W = PROC_DATA_W,
    parameter int ADDR_W = PROC_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_dir,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_dir,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rs_dir,
    input  logic [ADDR_W-1:0] rt_dir,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic              stall
);

    logic                      wb_valid;
    logic [ADDR_W-1:0]         wb_dir;
    logic [DATA_W-1:0]         wb_data;
    logic [DATA_W-1:0]         regs [PROC_REG_COUNT];
    logic [PROC_REG_COUNT-1:0] busy;
    logic                      commit;
    logic                      rs_bypass;
    logic                      rt_bypass;

    // Register 0 is never written, so it reads back as zero from reset onward.
    assign commit = wb_valid && (wb_dir != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_valid <= 1'b0;
            wb_dir   <= '0;
            wb_data  <= '0;
        end else begin
            wb_valid <= wr_en;
            wb_dir   <= wr_dir;
            wb_data  <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PROC_REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else if (commit) begin
            regs[wb_dir] <= wb_data;
        end
    end

    reg_scoreboard #(
        .ADDR_W    (ADDR_W),
        .REG_COUNT (PROC_REG_COUNT)
    ) u_scoreboard (
        .clk     (clk),
        .reset   (reset),
        .set_en  (issue_en),
        .set_dir (issue_dir),
        .clr_en  (commit),
        .clr_dir (wb_dir),
        .busy    (busy)
    );

    // A source served by the bypass already has its value, so it never stalls.
    always_comb begin
        rs_bypass = commit && (rs_dir == wb_dir);
        rt_bypass = commit && (rt_dir == wb_dir);
        rs_data   = rs_bypass ? wb_data : regs[rs_dir];
        rt_data   = rt_bypass ? wb_data : regs[rt_dir];
        stall     = (busy[rs_dir] && !rs_bypass) || (busy[rt_dir] && !rt_bypass);
        if (reset) begin
            rs_data = '0;
            rt_data = '0;
            stall   = 1'b0;
        end
    end

endmodule

// File: tb/tb_reg_bank_wb.sv
// Self-checking bench for reg_bank_wb: directed scenarios plus a randomized run
// compared against an event-level model of register visibility and hazards.
module tb_reg_bank_wb;

    logic        clk;
    logic        reset;
    logic        issue_en;
    logic [4:0]  issue_dir;
    logic        wr_en;
    logic [4:0]  wr_dir;
    logic [31:0] wr_data;
    logic [4:0]  rs_dir;
    logic [4:0]  rt_dir;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        stall;

    int total = 0;
    int bad   = 0;

    // Model: value a read returns, outstanding producers, and the write seen last edge.
    logic [31:0] m_val [32];
    bit          m_pending [32];
    bit          m_last_wr;
    logic [4:0]  m_last_dir;

    reg_bank_wb dut (
        .clk       (clk),
        .reset     (reset),
        .issue_en  (issue_en),
        .issue_dir (issue_dir),
        .wr_en     (wr_en),
        .wr_dir    (wr_dir),
        .wr_data   (wr_data),
        .rs_dir    (rs_dir),
        .rt_dir    (rt_dir),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .stall     (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_val[i]     = '0;
            m_pending[i] = 1'b0;
        end
        m_last_wr  = 1'b0;
        m_last_dir = '0;
    endtask

    // A write becomes readable one edge after it is presented; its producer
    // reservation is released one edge later unless re-reserved on that edge.
    task automatic model_edge();
        if (m_last_wr && m_last_dir != 0) m_pending[m_last_dir] = 1'b0;
        if (issue_en && issue_dir != 0) m_pending[issue_dir] = 1'b1;
        if (wr_en && wr_dir != 0) m_val[wr_dir] = wr_data;
        m_last_wr  = wr_en;
        m_last_dir = wr_dir;
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        return (a == 0) ? 32'h0 : m_val[a];
    endfunction

    function automatic bit exp_src_stall(input logic [4:0] a);
        return m_pending[a] && !(m_last_wr && m_last_dir == a && a != 0);
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        issue_en  = 1'b0;
        issue_dir = '0;
        wr_en     = 1'b0;
        wr_dir    = '0;
        wr_data   = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        rs_dir = 5'd7;
        rt_dir = 5'd0;
        model_reset();
        #12;
        total++;
        if (rs_data !== 32'h0 || rt_data !== 32'h0 || stall !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_hold rs=%h rt=%h stall=%b required 0/0/0", rs_data, rt_data, stall);
        end
        #5;
        reset = 1'b0;
        #2;
        total++;
        if (rs_data !== 32'h0 || stall !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_release rs=%h stall=%b required 0/0", rs_data, stall);
        end
    endtask

    task automatic test_reset_mid_write();
        tick();
        wr_en = 1'b1; wr_dir = 5'd5; wr_data = 32'h1234;
        issue_en = 1'b1; issue_dir = 5'd5;
        rs_dir = 5'd5; rt_dir = 5'd5;
        tick();
        idle_inputs();
        #1;
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #2;
        reset = 1'b0;
        #2;
        total++;
        if (rs_data !== 32'h0 || rt_data !== 32'h0) begin
            bad++;
            $display("[TB] FAIL midwrite_data rs=%h rt=%h required 0", rs_data, rt_data);
        end
        total++;
        if (stall !== 1'b0) begin
            bad++;
            $display("[TB] FAIL midwrite_stall stall=%b required 0", stall);
        end
        tick();
        total++;
        if (rs_data !== 32'h0) begin
            bad++;
            $display("[TB] FAIL midwrite_later rs=%h required 0", rs_data);
        end
    endtask

    task automatic test_bypass();
        wr_en = 1'b1; wr_dir = 5'd8; wr_data = 32'hDEADBEEF;
        rs_dir = 5'd8; rt_dir = 5'd0;
        #2;
        total++;
        if (rs_data !== 32'h0) begin
            bad++;
            $display("[TB] FAIL bypass_early rs=%h required 0", rs_data);
        end
        tick();
        idle_inputs();
        for (int c = 0; c < 3; c++) begin
            #2;
            total++;
            if (rs_data !== 32'hDEADBEEF) begin
                bad++;
                $display("[TB] FAIL bypass_c%0d rs=%h required deadbeef", c, rs_data);
            end
            tick();
        end
    endtask

    task automatic test_zero_reg();
        wr_en = 1'b1; wr_dir = 5'd0; wr_data = 32'hFFFFFFFF;
        issue_en = 1'b1; issue_dir = 5'd0;
        rs_dir = 5'd0; rt_dir = 5'd0;
        for (int c = 0; c < 4; c++) begin
            tick();
            #2;
            total++;
            if (rt_data !== 32'h0 || rs_data !== 32'h0 || stall !== 1'b0) begin
                bad++;
                $display("[TB] FAIL zero_c%0d rs=%h rt=%h stall=%b required 0/0/0", c, rs_data, rt_data, stall);
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_hazard();
        issue_en = 1'b1; issue_dir = 5'd15;
        tick();
        idle_inputs();
        rs_dir = 5'd15; rt_dir = 5'd0;
        for (int c = 0; c < 3; c++) begin
            #2;
            total++;
            if (stall !== 1'b1) begin
                bad++;
                $display("[TB] FAIL hazard_wait_c%0d stall=%b required 1", c, stall);
            end
            if (c < 2) tick();
        end
        wr_en = 1'b1; wr_dir = 5'd15; wr_data = 32'h0BADF00D;
        #1;
        total++;
        if (stall !== 1'b1) begin
            bad++;
            $display("[TB] FAIL hazard_precapture stall=%b required 1", stall);
        end
        tick();
        idle_inputs();
        for (int c = 0; c < 2; c++) begin
            #2;
            total++;
            if (stall !== 1'b0 || rs_data !== 32'h0BADF00D) begin
                bad++;
                $display("[TB] FAIL hazard_done_c%0d stall=%b rs=%h required 0/0badf00d", c, stall, rs_data);
            end
            tick();
        end
    endtask

    task automatic test_same_edge();
        issue_en = 1'b1; issue_dir = 5'd10;
        tick();
        idle_inputs();
        wr_en = 1'b1; wr_dir = 5'd10; wr_data = 32'h00C0FFEE;
        tick();
        idle_inputs();
        issue_en = 1'b1; issue_dir = 5'd10;
        tick();
        idle_inputs();
        rs_dir = 5'd10; rt_dir = 5'd0;
        #2;
        total++;
        if (stall !== 1'b1) begin
            bad++;
            $display("[TB] FAIL same_edge_stall stall=%b required 1", stall);
        end
        total++;
        if (rs_data !== 32'h00C0FFEE) begin
            bad++;
            $display("[TB] FAIL same_edge_data rs=%h required 00c0ffee", rs_data);
        end
        wr_en = 1'b1; wr_dir = 5'd10; wr_data = 32'h11111111;
        tick();
        idle_inputs();
        tick();
        #2;
        total++;
        if (stall !== 1'b0) begin
            bad++;
            $display("[TB] FAIL same_edge_release stall=%b required 0", stall);
        end
    endtask

    task automatic test_back_to_back();
        wr_en = 1'b1; wr_dir = 5'd3; wr_data = 32'hA;
        tick();
        wr_data = 32'hF;
        tick();
        idle_inputs();
        rs_dir = 5'd3; rt_dir = 5'd3;
        for (int c = 0; c < 3; c++) begin
            #2;
            total++;
            if (rs_data !== 32'hF || rt_data !== 32'hF) begin
                bad++;
                $display("[TB] FAIL b2b_c%0d rs=%h rt=%h required f", c, rs_data, rt_data);
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            issue_en  = ($urandom_range(0, 3) == 0);
            issue_dir = 5'($urandom_range(0, 7));
            wr_en     = ($urandom_range(0, 1) == 0);
            wr_dir    = 5'($urandom_range(0, 7));
            wr_data   = $urandom;
            rs_dir    = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            rt_dir    = 5'($urandom_range(0, 7));
            #2;
            total++;
            if (rs_data !== exp_rd(rs_dir)) begin
                bad++;
                $display("[TB] FAIL rand_rs cycle=%0d dir=%0d got=%h exp=%h", c, rs_dir, rs_data, exp_rd(rs_dir));
            end
            total++;
            if (rt_data !== exp_rd(rt_dir)) begin
                bad++;
                $display("[TB] FAIL rand_rt cycle=%0d dir=%0d got=%h exp=%h", c, rt_dir, rt_data, exp_rd(rt_dir));
            end
            total++;
            if (stall !== (exp_src_stall(rs_dir) || exp_src_stall(rt_dir))) begin
                bad++;
                $display("[TB] FAIL rand_stall cycle=%0d got=%b exp=%b", c, stall,
                         exp_src_stall(rs_dir) || exp_src_stall(rt_dir));
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_reset_mid_write();
        test_bypass();
        test_zero_reg();
        test_hazard();
        test_same_edge();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
